cnt4_reg_stage: RTL and testbench



---
 rtl/cnt4_pkg.sv | 14 +
 rtl/cnt4_next_inc.sv | 24 ++
 rtl/cnt4_reg_stage.sv | 98 +++++++++
 tb/tb_cnt4_reg_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnt4_pkg.sv
// rtl/cnt4_pkg.sv - shared constants and operation decode type for the 4-bit count stage
package cnt4_pkg;

    localparam int CNT_W           = 4;
    localparam int CNT_MOD_MAX_DEF = 15;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/cnt4_next_inc.sv
// rtl/cnt4_next_inc.sv - combinational increment and at-max compare for the count stage
module cnt4_next_inc
    import cnt4_pkg::*;
#(
    parameter int WIDTH   = CNT_W,
    parameter int MOD_MAX = CNT_MOD_MAX_DEF
) (
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_inc,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MOD_MAX_V = WIDTH'(MOD_MAX);

    logic [WIDTH:0] sum;
    logic           unused_carry;

    // Carry is dropped on purpose: rollover is decided by the at-max compare.
    assign sum          = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    assign count_inc    = sum[WIDTH-1:0];
    assign unused_carry = sum[WIDTH];
    assign at_max       = (count >= MOD_MAX_V);

endmodule

// File: rtl/cnt4_reg_stage.sv
// rtl/cnt4_reg_stage.sv - registered count stage with clear, load, modulo wrap, cascade tc and sticky overflow
// Optional build macro CNT4_SATURATE_EN: hold at MOD_MAX instead of wrapping to zero.
module cnt4_reg_stage
    import cnt4_pkg::*;
#(
    parameter int WIDTH   = CNT_W,
    parameter int MOD_MAX = CNT_MOD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MOD_MAX_V = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] count_inc;
    logic             at_max;
    cnt_op_e          op;

    cnt4_next_inc #(
        .WIDTH   (WIDTH),
        .MOD_MAX (MOD_MAX)
    ) u_next_inc (
        .count     (count_q),
        .count_inc (count_inc),
        .at_max    (at_max)
    );

    always_comb begin
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_INC;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        case (op)
            OP_CLR: begin
                count_d = '0;
                ovf_d   = 1'b0;
            end
            OP_LOAD: begin
                count_d = load_val;
            end
            OP_INC: begin
                if (at_max) begin
                    ovf_d = 1'b1;
`ifdef CNT4_SATURATE_EN
                    count_d = MOD_MAX_V;
`else
                    count_d = '0;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_inc;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;
    assign tc    = en && at_max;

endmodule

// File: tb/tb_cnt4_reg_stage.sv
// tb/tb_cnt4_reg_stage.sv - self-checking bench for cnt4_reg_stage (honours CNT4_SATURATE_EN)
module tb_cnt4_reg_stage;

`ifdef CNT4_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       en = 1'b0;

    logic [3:0] cnt15, cnt9, cnt1;
    logic       tc15, tc9, tc1, wrap15, wrap9, wrap1, ovf15, ovf9, ovf1;

    logic       c_clr = 1'b0;
    logic       c_load = 1'b0;
    logic [3:0] c_load_val = 4'd0;
    logic       c_en = 1'b0;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_tc, lo_wrap, lo_ovf, hi_tc, hi_wrap, hi_ovf;

    int checks = 0;
    int errors = 0;

    int m_cnt[3];
    bit m_wrap[3];
    bit m_ovf[3];
    int mods[3] = '{15, 9, 1};

    always #5 clk = ~clk;

    cnt4_reg_stage #(.WIDTH(4), .MOD_MAX(15)) dut15 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .count(cnt15), .tc(tc15), .wrap(wrap15), .ovf(ovf15));
    cnt4_reg_stage #(.WIDTH(4), .MOD_MAX(9)) dut9 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .count(cnt9), .tc(tc9), .wrap(wrap9), .ovf(ovf9));
    cnt4_reg_stage #(.WIDTH(4), .MOD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .count(cnt1), .tc(tc1), .wrap(wrap1), .ovf(ovf1));

    cnt4_reg_stage #(.WIDTH(4), .MOD_MAX(15)) casc_lo (
        .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .load_val(c_load_val), .en(c_en),
        .count(lo_cnt), .tc(lo_tc), .wrap(lo_wrap), .ovf(lo_ovf));
    cnt4_reg_stage #(.WIDTH(4), .MOD_MAX(15)) casc_hi (
        .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .load_val(c_load_val), .en(lo_tc),
        .count(hi_cnt), .tc(hi_tc), .wrap(hi_wrap), .ovf(hi_ovf));

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic [3:0] e_cnt;
        logic       e_wrap;
        logic       e_ovf;
        logic       e_tc;
    } vec_t;

    vec_t tbl[9];

    task automatic expect_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: count rules expressed directly as arithmetic on an integer count.
    task automatic model_edge(input bit c, input bit l, input int lv, input bit e);
        for (int k = 0; k < 3; k++) begin
            m_wrap[k] = 1'b0;
            if (c) begin
                m_cnt[k] = 0;
                m_ovf[k] = 1'b0;
            end else if (l) begin
                m_cnt[k] = lv;
            end else if (e) begin
                if (m_cnt[k] >= mods[k]) begin
                    m_ovf[k]  = 1'b1;
                    m_wrap[k] = !SAT;
                    m_cnt[k]  = SAT ? mods[k] : 0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 0;
            m_wrap[k] = 1'b0;
            m_ovf[k]  = 1'b0;
        end
    endtask

    task automatic check_one(input string nm, input int k, input logic [3:0] c, input logic w,
                             input logic o, input logic t);
        expect_eq({nm, ".count"}, int'(c), m_cnt[k]);
        expect_eq({nm, ".wrap"}, int'(w), int'(m_wrap[k]));
        expect_eq({nm, ".ovf"}, int'(o), int'(m_ovf[k]));
        expect_eq({nm, ".tc"}, int'(t), int'(en && (m_cnt[k] >= mods[k])));
    endtask

    task automatic check_all();
        check_one("m15", 0, cnt15, wrap15, ovf15, tc15);
        check_one("m9", 1, cnt9, wrap9, ovf9, tc9);
        check_one("m1", 2, cnt1, wrap1, ovf1, tc1);
    endtask

    task automatic apply(input bit c, input bit l, input logic [3:0] lv, input bit e);
        clr      = c;
        load     = l;
        load_val = lv;
        en       = e;
        @(posedge clk);
        model_edge(c, l, int'(lv), e);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        clr = 1'b0; load = 1'b0; en = 1'b0; load_val = 4'd0;
        c_clr = 1'b0; c_load = 1'b0; c_en = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1, 4'd14, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 4'd0,  1'b1, SAT ? 4'd15 : 4'd0, !SAT, 1'b1, SAT};
        tbl[3] = '{1'b0, 1'b0, 4'd0,  1'b0, SAT ? 4'd15 : 4'd0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 4'd5,  1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 4'd5,  1'b1, 4'd5,  1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'd15, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 4'd0,  1'b1, SAT ? 4'd15 : 4'd0, !SAT, 1'b1, SAT};

        do_reset();
        #1;
        check_all();

        // Cascade: upper stage advances only on the lower stage's terminal edge.
        c_en = 1'b1;
        for (int i = 0; i < 15; i++) @(posedge clk);
        #1;
        expect_eq("casc.lo_pre", int'(lo_cnt), 15);
        expect_eq("casc.hi_pre", int'(hi_cnt), 0);
        expect_eq("casc.lo_tc", int'(lo_tc), 1);
        @(posedge clk);
        #1;
        expect_eq("casc.lo_post", int'(lo_cnt), SAT ? 15 : 0);
        expect_eq("casc.hi_post", int'(hi_cnt), 1);
        c_en = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].en);
            expect_eq($sformatf("tbl%0d.count", i), int'(cnt15), int'(tbl[i].e_cnt));
            expect_eq($sformatf("tbl%0d.wrap", i), int'(wrap15), int'(tbl[i].e_wrap));
            expect_eq($sformatf("tbl%0d.ovf", i), int'(ovf15), int'(tbl[i].e_ovf));
            expect_eq($sformatf("tbl%0d.tc", i), int'(tc15), int'(tbl[i].e_tc));
        end

        // Free run for 17 edges from zero.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            apply(1'b0, 1'b0, 4'd0, 1'b1);
            expect_eq($sformatf("run15.e%0d", i), int'(cnt15), SAT ? ((i > 15) ? 15 : i) : (i % 16));
            expect_eq($sformatf("run9.e%0d", i), int'(cnt9), SAT ? ((i > 9) ? 9 : i) : (i % 10));
        end
        expect_eq("run15.ovf_sticky", int'(ovf15), 1);

        // Load above MOD_MAX then count.
        apply(1'b0, 1'b1, 4'd12, 1'b0);
        expect_eq("mod9.load12", int'(cnt9), 12);
        apply(1'b0, 1'b0, 4'd0, 1'b1);
        expect_eq("mod9.over_count", int'(cnt9), SAT ? 9 : 0);
        expect_eq("mod9.over_wrap", int'(wrap9), SAT ? 0 : 1);

        // Asynchronous reset mid-count at 9, checked before the next edge.
        apply(1'b0, 1'b1, 4'd8, 1'b0);
        apply(1'b0, 1'b0, 4'd0, 1'b1);
        expect_eq("areset.pre", int'(cnt15), 9);
        rst = 1'b1;
        #1;
        model_reset();
        expect_eq("areset.count", int'(cnt15), 0);
        expect_eq("areset.wrap", int'(wrap15), 0);
        expect_eq("areset.ovf", int'(ovf15), 0);
        expect_eq("areset.tc", int'(tc15), 0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

`ifdef CNT4_SATURATE_EN
        apply(1'b0, 1'b1, 4'd13, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 4'd0, 1'b1);
            expect_eq($sformatf("sat.count%0d", i), int'(cnt15), (i == 0) ? 14 : 15);
            expect_eq($sformatf("sat.wrap%0d", i), int'(wrap15), 0);
            expect_eq($sformatf("sat.ovf%0d", i), int'(ovf15), (i >= 2) ? 1 : 0);
        end
`endif

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 16) == 0, ($urandom % 8) == 0, 4'($urandom), ($urandom % 4) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
